// File: rtl/freq_div_cfg_seq.sv
// freq_div_cfg_seq
// Configuration sequencer that sits in front of the frequency divider. It turns
// divisor/run requests into a safe pin sequence on the divider: stop, settle for
// GAP_CYCLES, pulse ConfigDiv for one cycle, then restart if requested.
// Optional feature macro: DIVCFG_SHADOW_EN adds a one-entry shadow request buffer,
// so a request arriving while a load is in flight is chained straight after it.
module freq_div_cfg_seq #(
   parameter int GAP_CYCLES = 2,
   parameter int DIV_W      = 32
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             ReqValid,
   output logic             ReqReady,
   input  logic [DIV_W-1:0] ReqDiv,
   input  logic             ReqRun,
   input  logic             RunSet,
   input  logic             RunClr,
   input  logic             ErrClr,
   output logic [DIV_W-1:0] Din,
   output logic             ConfigDiv,
   output logic             Enable,
   output logic [DIV_W-1:0] CurDiv,
   output logic             Busy,
   output logic             Err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      STOP  = 2'd1,
      LOAD  = 2'd2,
      START = 2'd3
   } state_t;

   // The counter is reset to zero on STOP entry, so the last STOP cycle is GAP_CYCLES-1.
   localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

   state_t     state;
   logic [3:0] gap_cnt;
   logic       run_latch;
   logic       accept;
   logic       req_zero;
   logic       err_set;

   assign accept   = ReqValid && ReqReady;
   assign req_zero = (ReqDiv == '0);
   assign Busy     = (state != IDLE);

`ifdef DIVCFG_SHADOW_EN
   logic             shadow_valid;
   logic [DIV_W-1:0] shadow_div;
   logic             shadow_run;

   // Outside IDLE we are busy by definition, so ready means "shadow slot free".
   assign ReqReady = (state == IDLE) || !shadow_valid;

   // Shadow slot: filled by a legal request taken while busy, emptied when START
   // hands it (or a same-edge request) over to a fresh STOP phase.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         shadow_valid <= 1'b0;
         shadow_div   <= '0;
         shadow_run   <= 1'b0;
      end else if (state == START) begin
         shadow_valid <= 1'b0;
      end else if (accept && (state != IDLE) && !req_zero) begin
         shadow_valid <= 1'b1;
         shadow_div   <= ReqDiv;
         shadow_run   <= ReqRun;
      end
   end
`else
   assign ReqReady = (state == IDLE);
`endif

   // A zero divisor is flagged whenever it is accepted; RunSet only counts in IDLE,
   // when no request wins the edge, RunClr is not also asserted, and nothing is loaded yet.
   always_comb begin
      err_set = 1'b0;
      if (accept && req_zero) begin
         err_set = 1'b1;
      end else if ((state == IDLE) && !accept && RunSet && !RunClr && (CurDiv == '0)) begin
         err_set = 1'b1;
      end
   end

   // Sequencer FSM with registered divider pins: stop, settle, load strobe, restart.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state     <= IDLE;
         gap_cnt   <= '0;
         run_latch <= 1'b0;
         Din       <= '0;
         ConfigDiv <= 1'b0;
         Enable    <= 1'b0;
         CurDiv    <= '0;
      end else begin
         ConfigDiv <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (!req_zero) begin
                     Din       <= ReqDiv;
                     run_latch <= ReqRun;
                     Enable    <= 1'b0;
                     gap_cnt   <= '0;
                     state     <= STOP;
                  end
               end else if (RunClr) begin
                  Enable <= 1'b0;
               end else if (RunSet && (CurDiv != '0)) begin
                  Enable <= 1'b1;
               end
            end
            STOP: begin
               Enable <= 1'b0;
               if (gap_cnt == GAP_LAST) begin
                  gap_cnt   <= '0;
                  ConfigDiv <= 1'b1;
                  state     <= LOAD;
               end else begin
                  gap_cnt <= gap_cnt + 4'd1;
               end
            end
            LOAD: begin
               CurDiv <= Din;
               state  <= START;
            end
            START: begin
`ifdef DIVCFG_SHADOW_EN
               if (shadow_valid) begin
                  Din       <= shadow_div;
                  run_latch <= shadow_run;
                  Enable    <= 1'b0;
                  gap_cnt   <= '0;
                  state     <= STOP;
               end else if (accept && !req_zero) begin
                  Din       <= ReqDiv;
                  run_latch <= ReqRun;
                  Enable    <= 1'b0;
                  gap_cnt   <= '0;
                  state     <= STOP;
               end else begin
                  Enable <= run_latch;
                  state  <= IDLE;
               end
`else
               Enable <= run_latch;
               state  <= IDLE;
`endif
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Sticky error flag; a new error event on the same edge beats ErrClr.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         Err <= 1'b0;
      end else if (err_set) begin
         Err <= 1'b1;
      end else if (ErrClr) begin
         Err <= 1'b0;
      end
   end

endmodule
